mirror_display_driver: RTL and testbench

MIRROR_DISPLAY_DRIVER -- requirements
Module: mirror_display_driver

---
 rtl/mirror_display_pkg.sv | 51 +++++
 rtl/bin8_to_bcd3.sv | 48 ++++
 rtl/mirror_display_driver.sv | 117 +++++++++++
 tb/tb_mirror_display_driver.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mirror_display_pkg.sv
// mirror_display_pkg -- shared definitions for the mirror display driver.
//   state_t     : conversion FSM states (IDLE, CONVERT, LOAD)
//   SS_*        : data-type select encodings
//   SEG_* / LET_*: active-low 7-segment codes {g,f,e,d,c,b,a}
//   digit_seg() : BCD digit -> segment code
//   mode_seg()  : SS encoding -> mode letter code
package mirror_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    localparam logic [1:0] SS_TEMP     = 2'd0;
    localparam logic [1:0] SS_AVG_MPG  = 2'd1;
    localparam logic [1:0] SS_INST_MPG = 2'd2;
    localparam logic [1:0] SS_MILES    = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] LET_T     = 7'h07;
    localparam logic [6:0] LET_A     = 7'h08;
    localparam logic [6:0] LET_I     = 7'h4F;
    localparam logic [6:0] LET_R     = 7'h2F;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] mode_seg(input logic [1:0] ss);
        case (ss)
            SS_TEMP:     return LET_T;
            SS_AVG_MPG:  return LET_A;
            SS_INST_MPG: return LET_I;
            default:     return LET_R;
        endcase
    endfunction

endpackage

// File: rtl/bin8_to_bcd3.sv
// bin8_to_bcd3 -- 8-bit binary to 3-digit BCD, shift-add-3 (double dabble),
// one bit per cycle, MSB first, 8 cycles per conversion.
//   clk, reset : clock, synchronous active-high reset
//   start      : load din and begin a conversion (restarts any in progress)
//   din        : binary input 0..255
//   done       : high during the cycle whose edge performs the final shift
//   bcd        : {hundreds, tens, ones}; final once the last shift has landed
module bin8_to_bcd3 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  din,
    output logic        done,
    output logic [11:0] bcd
);
    logic [7:0]  sh;
    logic [3:0]  cnt;
    logic [11:0] adj;

    // Add 3 to any nibble >= 5 before the shift so it carries correctly.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh  <= '0;
            bcd <= '0;
            cnt <= '0;
        end else if (start) begin
            sh  <= din;
            bcd <= '0;
            cnt <= 4'd8;
        end else if (cnt != 4'd0) begin
            {bcd, sh} <= {adj[10:0], sh, 1'b0};
            cnt       <= cnt - 4'd1;
        end
    end

    // Combinational so the FSM can leave CONVERT on the same edge as the
    // last shift, keeping the conversion at exactly 8 cycles.
    assign done = (cnt == 4'd1);

endmodule

// File: rtl/mirror_display_driver.sv
// mirror_display_driver -- converts the selected 8-bit mirror value to BCD
// and multiplexes mode letter + three digits onto a 4-digit 7-seg display.
//   clk, reset : clock, synchronous active-high reset
//   Display    : value 0..255;  SS : data type (letter shown on leftmost digit)
//   seg, an    : registered active-low segments / digit enables (an[0] right)
//   dp         : decimal point, always off (1)
//   busy       : high in CONVERT and LOAD
// Build option: define MIRROR_DISPLAY_LEADING_ZERO_BLANK_EN to blank leading
// zeros in the hundreds/tens digits.
module mirror_display_driver
    import mirror_display_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Display,
    input  logic [1:0] SS,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t          state;
    logic            pending;
    logic [7:0]      cap_val;
    logic [1:0]      cap_ss;
    logic [3:0][6:0] digits;
    logic [CW-1:0]   scan_cnt;
    logic [1:0]      idx;
    logic            trigger, start, bcd_done;
    logic [11:0]     bcd;
    logic [6:0]      d2_code, d1_code;

    assign trigger = pending || (Display != cap_val) || (SS != cap_ss);
    // LOAD re-checks the inputs and chains straight into a new conversion,
    // so a change that arrived mid-conversion costs no idle cycle.
    assign start   = trigger && (state == IDLE || state == LOAD);
    assign busy    = (state != IDLE);
    assign dp      = 1'b1;

    bin8_to_bcd3 u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .din   (Display),
        .done  (bcd_done),
        .bcd   (bcd)
    );

`ifdef MIRROR_DISPLAY_LEADING_ZERO_BLANK_EN
    assign d2_code = (bcd[11:8] == 4'd0) ? SEG_BLANK : digit_seg(bcd[11:8]);
    assign d1_code = (bcd[11:4] == 8'd0) ? SEG_BLANK : digit_seg(bcd[7:4]);
`else
    assign d2_code = digit_seg(bcd[11:8]);
    assign d1_code = digit_seg(bcd[7:4]);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pending <= 1'b1;
            cap_val <= '0;
            cap_ss  <= '0;
            digits  <= {4{SEG_BLANK}};
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        cap_val <= Display;
                        cap_ss  <= SS;
                        pending <= 1'b0;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (bcd_done) state <= LOAD;
                end
                LOAD: begin
                    digits <= {mode_seg(cap_ss), d2_code, d1_code,
                               digit_seg(bcd[3:0])};
                    if (trigger) begin
                        cap_val <= Display;
                        cap_ss  <= SS;
                        state   <= CONVERT;
                    end else begin
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Scan: seg reads the whole digit register set in one edge, so a LOAD
    // never produces a half-updated digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg      <= SEG_BLANK;
            an       <= 4'hF;
        end else begin
            if (scan_cnt == CW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            seg <= digits[idx];
            an  <= ~(4'b0001 << idx);
        end
    end

endmodule

// File: tb/tb_mirror_display_driver.sv
module tb_mirror_display_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] Display = 8'd0;
    logic [1:0] SS = 2'd0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;

    int checks = 0;
    int failures = 0;

    mirror_display_driver #(.SCAN_DIV(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .Display (Display),
        .SS      (SS),
        .seg     (seg),
        .an      (an),
        .dp      (dp),
        .busy    (busy)
    );

    always #5 clk = ~clk;

`ifdef MIRROR_DISPLAY_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] Z = 7'h7F;
    localparam bit LZB = 1'b1;
`else
    localparam logic [6:0] Z = 7'h40;
    localparam bit LZB = 1'b0;
`endif

    typedef struct {
        logic [7:0]      disp;
        logic [1:0]      ss;
        logic [3:0][6:0] exp;
    } vec_t;

    logic [6:0] dig_tab [10];
    logic [6:0] let_tab [4];
    logic [3:0][6:0] cur;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Reference: decimal digits by plain arithmetic.
    function automatic logic [3:0][6:0] model(input int v, input int s);
        logic [3:0][6:0] r;
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        r[3] = let_tab[s];
        r[2] = (LZB && h == 0) ? 7'h7F : dig_tab[h];
        r[1] = (LZB && h == 0 && t == 0) ? 7'h7F : dig_tab[t];
        r[0] = dig_tab[o];
        return r;
    endfunction

    task automatic chk_seg(input string name, input logic [3:0][6:0] m);
        int i;
        i = idx_of(an);
        if (i < 0) chk({name, "_an"}, {28'd0, an}, 32'hE);
        else       chk(name, {25'd0, seg}, {25'd0, m[i]});
    endtask

    // Watch n cycles of scanning: seg matches the digit selected, the an
    // pattern advances in order and each pattern is held SCAN_DIV cycles.
    task automatic scan_check(input int n);
        int prev, run, i;
        bit first;
        prev = -1; run = 0; first = 1'b1;
        for (int c = 0; c < n; c++) begin
            tick();
            chk_seg("scan_seg", cur);
            i = idx_of(an);
            if (prev >= 0 && i != prev) begin
                if (!first) chk("scan_hold", run, 4);
                chk("scan_order", i, (prev + 1) % 4);
                first = 1'b0;
                run = 1;
            end else begin
                run++;
            end
            prev = i;
        end
    endtask

    // Inputs already changed; the next edge samples the change.
    task automatic run_conv(input logic [3:0][6:0] exp);
        int nb;
        nb = 0;
        tick();
        for (int c = 0; c < 40 && busy; c++) begin
            nb++;
            tick();
        end
        chk("busy_len", nb, 9);
        chk_seg("seg_old", cur);
        tick();
        chk_seg("seg_new", exp);
        cur = exp;
        scan_check(16);
    endtask

    initial begin
        vec_t vt [6];
        logic [3:0][6:0] e37, e142;
        int nb, v, s;

        dig_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        let_tab = '{7'h07, 7'h08, 7'h4F, 7'h2F};

        vt[0] = '{8'd255, 2'd3, {7'h2F, 7'h24, 7'h12, 7'h12}};
        vt[1] = '{8'd7,   2'd1, {7'h08, Z,     Z,     7'h78}};
        vt[2] = '{8'd142, 2'd2, {7'h4F, 7'h79, 7'h19, 7'h24}};
        vt[3] = '{8'd99,  2'd0, {7'h07, Z,     7'h10, 7'h10}};
        vt[4] = '{8'd100, 2'd1, {7'h08, 7'h79, 7'h40, 7'h40}};
        vt[5] = '{8'd10,  2'd2, {7'h4F, Z,     7'h79, 7'h40}};

        // Reset state
        repeat (3) tick();
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("dp", {31'd0, dp}, 1);

        // Pending flag forces conversion of 0 / temperature after release
        cur = {4{7'h7F}};
        reset = 1'b0;
        run_conv({7'h07, Z, Z, 7'h40});

        // Table vectors
        for (int k = 0; k < 6; k++) begin
            Display = vt[k].disp;
            SS = vt[k].ss;
            run_conv(vt[k].exp);
        end

        // Change arriving mid-conversion chains a second conversion
        e37 = model(37, 2);
        e142 = model(142, 2);
        Display = 8'd37;
        tick();
        nb = 0;
        for (int c = 0; c < 60 && busy; c++) begin
            nb++;
            if (c == 1) Display = 8'd142;
            if (c == 10) chk_seg("chain_first", e37);
            tick();
        end
        chk("chain_busy_len", nb, 18);
        chk_seg("chain_old", e37);
        tick();
        chk_seg("chain_new", e142);
        cur = e142;
        scan_check(16);

        // Reset in the middle of a conversion
        Display = 8'd99;
        SS = 2'd0;
        tick();
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("midrst_seg", {25'd0, seg}, 32'h7F);
        chk("midrst_an", {28'd0, an}, 32'hF);
        chk("midrst_busy", {31'd0, busy}, 0);
        reset = 1'b0;
        cur = {4{7'h7F}};
        run_conv(model(99, 0));

        // Random values against the arithmetic model
        for (int k = 0; k < 20; k++) begin
            do begin
                v = $urandom_range(255, 0);
                s = $urandom_range(3, 0);
            end while (v == int'(Display) && s == int'(SS));
            Display = 8'(v);
            SS = 2'(s);
            run_conv(model(v, s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
